serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The parameter list SHALL be:
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 The ports SHALL be:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to begin an operation; sampled on rising clk.
- sub  input  1  mode, captured with start: 0 = add, 1 = subtract (X - Y).
- X  input  WIDTH  operand A, captured with start.
- Y  input  WIDTH  operand B, captured with start.
- Cin  input  1  carry-in for add mode, captured with start; ignored when sub=1.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: result valid.
- Z  output  WIDTH  result; held stable from done until the next accepted start.
- Cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-003 The block SHALL compute one result bit per cycle, LSB first, through a single 1-bit full-adder cell and a 1-bit carry register.
REQ-004 The state machine SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> IDLE after one cycle, or DONE -> RUN if start=1 in that cycle.
REQ-005 On the edge that accepts start, the block SHALL:
- latch X, Y, sub and Cin;
- clear the bit counter;
- load the carry register with Cin (add) or 1 (sub).
REQ-006 In sub mode the B input of the adder cell SHALL be the inverted bit of Y, giving X + ~Y + 1.
REQ-007 With start accepted at edge k:
- bit i SHALL be computed at edge k+1+i;
- done SHALL be high during the cycle after edge k+WIDTH, giving a latency of WIDTH+1 cycles from start to done.
REQ-008 Z, Cout and overflow SHALL be updated only at the end of the last bit-cycle, and SHALL never expose partial sums.
REQ-009 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.
REQ-010 start asserted in RUN SHALL be ignored, with no effect on the operands or the operation in flight.
REQ-011 start asserted in DONE SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-012 Input changes on X, Y, sub and Cin outside the accepting edge SHALL NOT affect the result.
REQ-013 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL saturate at WIDTH-1, never wrapping within an operation.

Reset
REQ-014 Asserting rst_n=0 SHALL immediately force all of the following, including mid-operation:
- state = IDLE;
- busy = 0, done = 0, Z = 0, Cout = 0, overflow = 0;
- carry register and bit counter = 0.
REQ-015 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising clk edge with rst_n=1.

Structure
REQ-016 A shared package serial_adder_pkg SHALL hold:
- the state typedef/encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
- the default WIDTH constant.
REQ-017 The 1-bit full adder SHALL be a separate purely combinational sub-module, full_add_cell, with ports a, b, ci, s and co.
REQ-018 The operand shift registers, result shift register, carry register, counter and FSM SHALL reside in serial_adder.

Verification (WIDTH=8 unless stated)
REQ-019 Add with signed overflow: X=0x7F, Y=0x01, Cin=0, sub=0 -> done exactly 9 cycles after start; Z=0x80, Cout=0, overflow=1.
REQ-020 Add with carry out: X=0xFF, Y=0x01, Cin=0 -> Z=0x00, Cout=1, overflow=0; with Cin=1 -> Z=0x01, Cout=1.
REQ-021 Subtract with borrow: X=0x05, Y=0x07, sub=1, Cin=1 (ignored) -> Z=0xFE, Cout=0, overflow=0.
REQ-022 Handshake:
- start pulsed again 3 cycles into RUN with X=0x00, Y=0x00 -> ignored; first result unchanged.
- start held high through DONE -> second operation begins with no idle cycle.
REQ-023 Reset mid-operation: rst_n=0 at bit-cycle 4 -> busy, done, Z, Cout and overflow are 0 immediately; a fresh start after release yields a correct result.
REQ-024 Exhaustive check at WIDTH=4: all 2x256x2 combinations of sub, X/Y and Cin, compared against a reference model {Cout,Z} = X + (sub ? ~Y+1 : Y+Cin) and its overflow; zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single
// full-adder cell; results are published only when the last bit completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             Cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-2:0] z_sr;
    logic             sub_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic b_bit;
    logic s_bit;
    logic co_bit;
    logic last;

    // Subtraction is X + ~Y + 1: invert Y here, the +1 comes from the carry preload.
    assign b_bit = y_sr[0] ^ sub_r;
    assign last  = (cnt == CW'(WIDTH - 1));

    full_add_cell u_cell (
        .a  (x_sr[0]),
        .b  (b_bit),
        .ci (carry),
        .s  (s_bit),
        .co (co_bit)
    );

    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values, exactly like the flops they model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_sr     <= '0;
            y_sr     <= '0;
            z_sr     <= '0;
            sub_r    <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Z        <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    x_sr  <= x_sr >> 1;
                    y_sr  <= y_sr >> 1;
                    z_sr  <= (z_sr >> 1) | ((WIDTH-1)'(s_bit) << (WIDTH - 2));
                    carry <= co_bit;
                    if (last) begin
                        // carry still holds the carry into the MSB on this cycle
                        Z        <= {s_bit, z_sr};
                        Cout     <= co_bit;
                        overflow <= carry ^ co_bit;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept start; DONE -> RUN gives back-to-back ops.
                    done <= 1'b0;
                    if (start) begin
                        x_sr  <= X;
                        y_sr  <= Y;
                        sub_r <= sub;
                        carry <= sub | Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
